// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU.
// Latches decoded operands/control, inserts bubbles on hazards and flushes,
// and owns the multi-cycle divide interlock (start pulse, busy, ID stall).
module id_ex_stage #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [4:0]       id_shamt,
    input  logic [2:0]       id_alu_sel,
    input  logic             id_is_div,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [4:0]       id_rd,
    input  logic             hz_stall,
    input  logic             flush,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [4:0]       ex_shamt,
    output logic [2:0]       ex_sel,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [4:0]       ex_rd,
    output logic             ex_valid,
    output logic             ex_div_reset,
    output logic             div_busy,
    output logic             id_stall
);

    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             div_done;
    logic             take_bubble;

    assign div_done    = (count == CNT_LAST);
    assign take_bubble = flush | hz_stall | ~id_valid;

    // State register: IDLE issues instructions, DIV holds the stage for the divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only a real, unkilled divide enters DIV; DIV leaves after DIV_CYCLES cycles
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!take_bubble && id_is_div) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Divide cycle counter: held at zero while idle, counts every cycle in DIV
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == DIV) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= '0;
        end
    end

    // Pipeline register: load, bubble, or hold the divide while the divider runs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_a         <= '0;
            ex_b         <= '0;
            ex_shamt     <= '0;
            ex_sel       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rd        <= '0;
            ex_valid     <= 1'b0;
            ex_div_reset <= 1'b0;
        end else if (state == DIV) begin
            ex_div_reset <= 1'b0;
            if (div_done) begin
                ex_a         <= '0;
                ex_b         <= '0;
                ex_shamt     <= '0;
                ex_sel       <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_rd        <= '0;
                ex_valid     <= 1'b0;
            end
        end else if (take_bubble) begin
            ex_a         <= '0;
            ex_b         <= '0;
            ex_shamt     <= '0;
            ex_sel       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rd        <= '0;
            ex_valid     <= 1'b0;
            ex_div_reset <= 1'b0;
        end else begin
            ex_a         <= id_rs_data;
            ex_b         <= id_rt_data;
            ex_shamt     <= id_shamt;
            ex_sel       <= id_alu_sel;
            ex_rd        <= id_rd;
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write & ~id_is_div;
            ex_mem_read  <= id_mem_read  & ~id_is_div;
            ex_mem_write <= id_mem_write & ~id_is_div;
            ex_div_reset <= id_is_div;
        end
    end

    // Interlock outputs: busy follows DIV, ID stalls on divide or load-use hazard
    always_comb begin
        div_busy = (state == DIV);
        id_stall = reset & (div_busy | hz_stall);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared each cycle against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [4:0]       id_shamt;
    logic [2:0]       id_alu_sel;
    logic             id_is_div;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic [4:0]       id_rd;
    logic             hz_stall;
    logic             flush;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [4:0]       ex_shamt;
    logic [2:0]       ex_sel;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [4:0]       ex_rd;
    logic             ex_valid;
    logic             ex_div_reset;
    logic             div_busy;
    logic             id_stall;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.WIDTH(WIDTH), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_shamt(id_shamt), .id_alu_sel(id_alu_sel), .id_is_div(id_is_div),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rd(id_rd),
        .hz_stall(hz_stall), .flush(flush),
        .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_sel(ex_sel),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_div_reset(ex_div_reset), .div_busy(div_busy), .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining divide cycles plus the expected EX contents
    logic [WIDTH-1:0] m_a, m_b;
    logic [4:0]       m_shamt, m_rd;
    logic [2:0]       m_sel;
    logic             m_rw, m_mr, m_mw, m_valid, m_dr, m_is_div;
    int               m_div_left = 0;

    task automatic modelBubble();
        m_a = '0; m_b = '0; m_shamt = '0; m_rd = '0; m_sel = '0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_valid = 0; m_dr = 0; m_is_div = 0;
    endtask

    initial modelBubble();

    // Model update on each edge (or asynchronous reset)
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelBubble();
            m_div_left = 0;
        end else if (m_div_left > 0) begin
            m_div_left = m_div_left - 1;
            m_dr = 0;
            if (m_div_left == 0) modelBubble();
        end else if (flush || hz_stall || !id_valid) begin
            modelBubble();
        end else begin
            m_a = id_rs_data; m_b = id_rt_data; m_shamt = id_shamt;
            m_sel = id_alu_sel; m_rd = id_rd; m_valid = 1;
            m_is_div = id_is_div;
            m_dr = id_is_div;
            m_rw = id_reg_write && !id_is_div;
            m_mr = id_mem_read && !id_is_div;
            m_mw = id_mem_write && !id_is_div;
            if (id_is_div) m_div_left = DIV_CYCLES;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (m_div_left > 0);
        checkOutput("ex_a", ex_a, m_a);
        checkOutput("ex_b", ex_b, m_b);
        checkOutput("ex_sel", 32'(ex_sel), 32'(m_sel));
        checkOutput("ex_valid", 32'(ex_valid), 32'(m_valid));
        checkOutput("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        checkOutput("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        checkOutput("ex_mem_write", 32'(ex_mem_write), 32'(m_mw));
        checkOutput("ex_div_reset", 32'(ex_div_reset), 32'(m_dr));
        checkOutput("div_busy", 32'(div_busy), 32'(exp_busy));
        checkOutput("id_stall", 32'(id_stall), 32'(reset && (exp_busy || hz_stall)));
        if (!m_is_div) begin
            checkOutput("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
            checkOutput("ex_rd", 32'(ex_rd), 32'(m_rd));
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] sh, input logic [2:0] sel, input logic dv,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [4:0] rd, input logic hz, input logic fl);
        id_valid = v; id_rs_data = rs; id_rt_data = rt; id_shamt = sh;
        id_alu_sel = sel; id_is_div = dv; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_rd = rd; hz_stall = hz; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int busy_cnt;
        int pulse_cnt;
        bit done;
        logic [31:0] cap_a, cap_b;

        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ex_valid", 32'(ex_valid), 0);
        checkOutput("rst_ex_a", ex_a, 0);
        checkOutput("rst_id_stall", 32'(id_stall), 0);
        #3 reset = 1'b1;

        // addu loads on the next edge
        applyStimulus(1, 32'h5, 32'h3, 0, 3'b010, 0, 1, 0, 0, 5'd8, 0, 0);
        tick();
        checkOutput("t2_ex_a", ex_a, 32'h5);
        checkOutput("t2_ex_b", ex_b, 32'h3);
        checkOutput("t2_ex_sel", 32'(ex_sel), 32'h2);
        checkOutput("t2_ex_rd", 32'(ex_rd), 8);
        checkOutput("t2_ex_reg_write", 32'(ex_reg_write), 1);
        checkOutput("t2_ex_valid", 32'(ex_valid), 1);
        checkOutput("t2_id_stall", 32'(id_stall), 0);

        // load-use bubble then the held instruction loads
        applyStimulus(1, 32'h11, 32'h22, 5'd4, 3'b011, 0, 1, 0, 0, 5'd9, 1, 0);
        #1 checkOutput("t3_id_stall_comb", 32'(id_stall), 1);
        tick();
        checkOutput("t3_bubble_valid", 32'(ex_valid), 0);
        checkOutput("t3_bubble_rw", 32'(ex_reg_write), 0);
        checkOutput("t3_id_stall", 32'(id_stall), 1);
        applyStimulus(1, 32'h11, 32'h22, 5'd4, 3'b011, 0, 1, 0, 0, 5'd9, 0, 0);
        tick();
        checkOutput("t3_load_a", ex_a, 32'h11);
        checkOutput("t3_load_shamt", 32'(ex_shamt), 4);
        checkOutput("t3_load_sel", 32'(ex_sel), 3);
        checkOutput("t3_load_rd", 32'(ex_rd), 9);
        checkOutput("t3_load_valid", 32'(ex_valid), 1);

        // flush together with hz_stall on an addu
        applyStimulus(1, 32'h7, 32'h8, 0, 3'b010, 0, 1, 0, 0, 5'd3, 1, 1);
        #1 checkOutput("t6_id_stall_comb", 32'(id_stall), 1);
        tick();
        checkOutput("t6_bubble_valid", 32'(ex_valid), 0);
        checkOutput("t6_bubble_rw", 32'(ex_reg_write), 0);
        checkOutput("t6_bubble_sel", 32'(ex_sel), 0);
        applyStimulus(1, 32'h7, 32'h8, 0, 3'b010, 0, 1, 0, 0, 5'd3, 0, 0);
        tick();
        checkOutput("t6_load_valid", 32'(ex_valid), 1);
        checkOutput("t6_load_a", ex_a, 32'h7);

        // asynchronous reset mid-stream with ex_valid high
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_async_valid", 32'(ex_valid), 0);
        checkOutput("t1_async_a", ex_a, 0);
        checkOutput("t1_async_sel", 32'(ex_sel), 0);
        checkOutput("t1_async_rw", 32'(ex_reg_write), 0);
        applyStimulus(0, 32'h9, 32'h9, 0, 3'b010, 0, 1, 0, 0, 5'd4, 0, 0);
        #2 reset = 1'b1;
        tick();
        checkOutput("t1_post_valid", 32'(ex_valid), 0);

        // divu 100/7 with mfhi waiting in ID
        applyStimulus(1, 32'd100, 32'd7, 0, 3'b000, 1, 1, 0, 0, 5'd10, 0, 0);
        tick();
        checkOutput("t4_start_pulse", 32'(ex_div_reset), 1);
        checkOutput("t4_busy", 32'(div_busy), 1);
        checkOutput("t4_id_stall", 32'(id_stall), 1);
        checkOutput("t4_valid", 32'(ex_valid), 1);
        checkOutput("t4_rw_forced", 32'(ex_reg_write), 0);
        cap_a = ex_a;
        cap_b = ex_b;
        applyStimulus(1, 0, 0, 0, 3'b100, 0, 1, 0, 0, 5'd11, 0, 0);
        busy_cnt = 1;
        pulse_cnt = 1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == 10) flush = 1'b1;
            if (i == 11) flush = 1'b0;
            tick();
            if (ex_div_reset) pulse_cnt++;
            if (div_busy) busy_cnt++;
            else done = 1;
        end
        checkOutput("t4_busy_done", 32'(done), 1);
        checkOutput("t4_busy_cycles", busy_cnt, 32);
        checkOutput("t4_pulse_cycles", pulse_cnt, 1);
        checkOutput("t4_end_bubble", 32'(ex_valid), 0);
        checkOutput("t4_end_stall", 32'(id_stall), 0);
        tick();
        checkOutput("t5_mfhi_sel", 32'(ex_sel), 32'h4);
        checkOutput("t5_mfhi_valid", 32'(ex_valid), 1);
        checkOutput("t5_mfhi_rd", 32'(ex_rd), 11);
        checkOutput("t5_hi", cap_a % cap_b, 2);
        checkOutput("t5_lo", cap_a / cap_b, 14);
        applyStimulus(1, 0, 0, 0, 3'b101, 0, 1, 0, 0, 5'd12, 0, 0);
        tick();
        checkOutput("t5_mflo_sel", 32'(ex_sel), 32'h5);

        // randomized traffic, including one asynchronous reset
        for (int i = 0; i < 900; i++) begin
            applyStimulus(($urandom % 8) != 0, $urandom, $urandom, 5'($urandom),
                          3'($urandom), ($urandom % 20) == 0, 1'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom),
                          ($urandom % 8) == 0, ($urandom % 10) == 0);
            if (i == 450) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
            tick();
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
